// File: rtl/fredkin_pkg.sv
// Shared Fredkin gate-function constants and counter types.
// Latency: none (declarations only).
// Backpressure: not applicable.
package fredkin_pkg;

    localparam logic FK_AND_TIE   = 1'b0;
    localparam logic FK_MUX_SEL_A = 1'b0;
    localparam logic FK_MUX_SEL_B = 1'b1;
    localparam int   FK_MAX_WIDTH = 16;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

endpackage

// File: rtl/fredkin_gate.sv
// Fredkin controlled-swap primitive: c passes through, a/b swap when c=1.
// Latency: combinational.
// Backpressure: not applicable.
module fredkin_gate (
    input  logic c_i,
    input  logic a_i,
    input  logic b_i,
    output logic p_o,
    output logic q_o,
    output logic r_o
);

    assign p_o = c_i;
    assign q_o = c_i ? b_i : a_i;
    assign r_o = c_i ? a_i : b_i;

endmodule

// File: rtl/fredkin_tcell.sv
// One counter bit: Fredkin-gated toggle with parallel-load override, async clear.
// Latency: one clock from t/ld to q.
// Backpressure: none; ld takes priority over t.
module fredkin_tcell (
    input  logic clk,
    input  logic rst_n,
    input  logic t,
    input  logic ld,
    input  logic d,
    output logic q,
    output logic qb
);

    logic bit_q;
    logic bit_d;
    logic tgl;
    logic unused_tgl_p;
    logic unused_tgl_r;
    logic unused_ld_p;
    logic unused_ld_r;

    // Swapping q with its complement under t yields q ^ t.
    fredkin_gate u_tgl (
        .c_i (t),
        .a_i (bit_q),
        .b_i (~bit_q),
        .p_o (unused_tgl_p),
        .q_o (tgl),
        .r_o (unused_tgl_r)
    );

    fredkin_gate u_ld (
        .c_i (ld),
        .a_i (tgl),
        .b_i (d),
        .p_o (unused_ld_p),
        .q_o (bit_d),
        .r_o (unused_ld_r)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_q <= 1'b0;
        end else begin
            bit_q <= bit_d;
        end
    end

    assign q  = bit_q;
    assign qb = ~bit_q;

endmodule

// File: rtl/fredkin_counter.sv
// Modulo-N up/down counter on a Fredkin carry/borrow chain; FREDKIN_COUNTER_SAT_EN selects saturation.
// Latency: one clock from load/en to q; tc combinational; wrap registered with q.
// Backpressure: none; load > en > hold at every edge.
module fredkin_counter
    import fredkin_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
`ifndef FREDKIN_COUNTER_SAT_EN
    // Only a full 2^WIDTH range wraps by toggling alone.
    localparam bit FULL_RANGE = (MODULUS == (1 << WIDTH));
`endif

    if (WIDTH < 2 || WIDTH > FK_MAX_WIDTH || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_param_check
        $error("fredkin_counter: illegal WIDTH/MODULUS combination");
    end

    dir_e             dir;
    logic             mux_sel;
    logic [WIDTH-1:0] t_chain;
    logic [WIDTH-1:1] sel_bit;
    logic [WIDTH-1:0] ld_val;
    logic [WIDTH-1:0] din_clamp;
    logic             force_ld;
    logic             at_max;
    logic             at_zero;
    logic             wrap_d;
    logic             wrap_q;

    assign dir        = up ? DIR_UP : DIR_DOWN;
    assign mux_sel    = (dir == DIR_UP) ? FK_MUX_SEL_B : FK_MUX_SEL_A;
    assign t_chain[0] = en;

    for (genvar i = 1; i < WIDTH; i++) begin : g_chain
        logic unused_mux_p;
        logic unused_mux_r;
        logic unused_and_p;
        logic unused_and_q;

        fredkin_gate u_dir (
            .c_i (mux_sel),
            .a_i (qb[i-1]),
            .b_i (q[i-1]),
            .p_o (unused_mux_p),
            .q_o (sel_bit[i]),
            .r_o (unused_mux_r)
        );

        fredkin_gate u_and (
            .c_i (t_chain[i-1]),
            .a_i (sel_bit[i]),
            .b_i (FK_AND_TIE),
            .p_o (unused_and_p),
            .q_o (unused_and_q),
            .r_o (t_chain[i])
        );
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        fredkin_tcell u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .t     (t_chain[i]),
            .ld    (force_ld),
            .d     (ld_val[i]),
            .q     (q[i]),
            .qb    (qb[i])
        );
    end

    always_comb begin
        at_max    = (q == MAX_VAL);
        at_zero   = (q == '0);
        tc        = en & ((up & at_max) | (~up & at_zero));
        din_clamp = (int'(din) < MODULUS) ? din : MAX_VAL;
`ifdef FREDKIN_COUNTER_SAT_EN
        // At the terminal value reload the same value instead of toggling past it.
        force_ld  = load | tc;
        ld_val    = load ? din_clamp : (up ? MAX_VAL : '0);
        wrap_d    = 1'b0;
`else
        force_ld  = load | (tc & ~FULL_RANGE);
        ld_val    = load ? din_clamp : (up ? '0 : MAX_VAL);
        wrap_d    = tc & ~load;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign wrap = wrap_q;

endmodule

// File: tb/tb_fredkin_counter.sv
// Bench for fredkin_counter: three instances (M=10, M=16, M=2) against a behavioural model.
`timescale 1ns/1ps
module tb_fredkin_counter;

`ifdef FREDKIN_COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam int NDUT = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] din;
    logic [3:0] q10, qb10, q16, qb16;
    logic [1:0] q2, qb2;
    logic       tc10, tc16, tc2;
    logic       wrap10, wrap16, wrap2;

    fredkin_counter #(.WIDTH(4), .MODULUS(10)) dut10 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .din(din),
        .q(q10), .qb(qb10), .tc(tc10), .wrap(wrap10)
    );
    fredkin_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .din(din),
        .q(q16), .qb(qb16), .tc(tc16), .wrap(wrap16)
    );
    fredkin_counter #(.WIDTH(2), .MODULUS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .din(din[1:0]),
        .q(q2), .qb(qb2), .tc(tc2), .wrap(wrap2)
    );

    always #5 clk = ~clk;

    int mods[NDUT]  = '{10, 16, 2};
    int masks[NDUT] = '{15, 15, 3};
    int mq[NDUT];
    bit mw[NDUT];
    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit         ld;
        bit         e;
        bit         u;
        logic [3:0] d;
        int         exp_q;
        bit         exp_tc;
        bit         exp_wrap;
    } vec_t;
    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] dut_q(input int k);
        case (k)
            0:       return 32'(q10);
            1:       return 32'(q16);
            default: return 32'(q2);
        endcase
    endfunction

    function automatic logic [31:0] dut_qb(input int k);
        case (k)
            0:       return 32'(qb10);
            1:       return 32'(qb16);
            default: return 32'(qb2);
        endcase
    endfunction

    function automatic logic [31:0] dut_tc(input int k);
        case (k)
            0:       return 32'(tc10);
            1:       return 32'(tc16);
            default: return 32'(tc2);
        endcase
    endfunction

    function automatic logic [31:0] dut_wrap(input int k);
        case (k)
            0:       return 32'(wrap10);
            1:       return 32'(wrap16);
            default: return 32'(wrap2);
        endcase
    endfunction

    function automatic int model_tc(input int k);
        return (en && ((up && mq[k] == mods[k] - 1) || (!up && mq[k] == 0))) ? 1 : 0;
    endfunction

    // Next state of every counter for the inputs present at the coming edge.
    task automatic model_edge();
        for (int k = 0; k < NDUT; k++) begin
            int d;
            int m;
            d = int'(din) & masks[k];
            m = mods[k];
            if (!rst_n) begin
                mq[k] = 0;
                mw[k] = 1'b0;
            end else if (load) begin
                mq[k] = (d < m) ? d : m - 1;
                mw[k] = 1'b0;
            end else if (!en) begin
                mw[k] = 1'b0;
            end else if (up) begin
                mw[k] = 1'b0;
                if (mq[k] != m - 1) mq[k] = mq[k] + 1;
                else if (!SAT) begin
                    mq[k] = 0;
                    mw[k] = 1'b1;
                end
            end else begin
                mw[k] = 1'b0;
                if (mq[k] != 0) mq[k] = mq[k] - 1;
                else if (!SAT) begin
                    mq[k] = m - 1;
                    mw[k] = 1'b1;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("%s.m%0d.q", tag, mods[k]), dut_q(k), mq[k]);
            check($sformatf("%s.m%0d.qb", tag, mods[k]), dut_qb(k), (~mq[k]) & masks[k]);
            check($sformatf("%s.m%0d.tc", tag, mods[k]), dut_tc(k), model_tc(k));
            check($sformatf("%s.m%0d.wrap", tag, mods[k]), dut_wrap(k), 32'(mw[k]));
        end
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        up    = 1'b1;
        load  = 1'b0;
        din   = 4'd0;
        for (int k = 0; k < NDUT; k++) begin
            mq[k] = 0;
            mw[k] = 1'b0;
        end

        // Reset held with en=1 while the clock runs.
        repeat (3) tick("rst");
        check("rst.qb10", 32'(qb10), 32'hF);
        rst_n = 1'b1;
        repeat (7) tick("cnt");
        check("cnt.q10", 32'(q10), 7);

        // Asynchronous clear between edges.
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            mq[k] = 0;
            mw[k] = 1'b0;
        end
        check("async.q10", 32'(q10), 0);
        check_all("async");
        tick("async_hold");
        rst_n = 1'b1;

        // Up wrap at MODULUS=10.
        repeat (9) tick("upw");
        check("upw.q10_at9", 32'(q10), 9);
        check("upw.tc10_at9", 32'(tc10), 1);
        tick("upw_edge");
        check("upw.q10_after", 32'(q10), SAT ? 9 : 0);
        check("upw.wrap10_pulse", 32'(wrap10), SAT ? 0 : 1);
        tick("upw_next");
        check("upw.wrap10_clear", 32'(wrap10), 0);

        // Down wrap from 1, then direction flip at 5.
        load = 1'b1; din = 4'd1;
        tick("dnw_ld");
        load = 1'b0; up = 1'b0;
        tick("dnw0");
        check("dnw.q10_zero", 32'(q10), 0);
        check("dnw.tc10_zero", 32'(tc10), 1);
        tick("dnw_edge");
        check("dnw.q10_after", 32'(q10), SAT ? 0 : 9);
        check("dnw.wrap10_pulse", 32'(wrap10), SAT ? 0 : 1);
        load = 1'b1; din = 4'd5;
        tick("flip_ld");
        load = 1'b0; up = 1'b1;
        tick("flip");
        check("flip.q10", 32'(q10), 6);

        // Table-driven vectors for load priority, clamp, direction and hold.
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 4'd12, 9, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 4'd3,  3, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 4'd0,  4, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 4'd0,  5, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 4'd0,  4, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 4'd0,  5, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 4'd9,  9, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 4'd3,  3, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 4'd0,  3, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 4'd15, 9, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 4'd0,  8, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 4'd0,  0, 1'b1, 1'b0};
        for (int i = 0; i < 12; i++) begin
            load = vecs[i].ld;
            en   = vecs[i].e;
            up   = vecs[i].u;
            din  = vecs[i].d;
            tick($sformatf("tbl%0d", i));
            check($sformatf("tbl%0d.q10", i), 32'(q10), vecs[i].exp_q);
            check($sformatf("tbl%0d.tc10", i), 32'(tc10), 32'(vecs[i].exp_tc));
            check($sformatf("tbl%0d.wrap10", i), 32'(wrap10), 32'(vecs[i].exp_wrap));
        end

        // Hold for five cycles at 4.
        load = 1'b1; en = 1'b0; din = 4'd4;
        tick("hold_ld");
        load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick("hold");
            check("hold.q10", 32'(q10), 4);
            check("hold.tc10", 32'(tc10), 0);
            check("hold.wrap10", 32'(wrap10), 0);
        end

        // Full-range counter at its ends (saturation when enabled).
        load = 1'b1; din = 4'd14;
        tick("m16_ld");
        load = 1'b0; en = 1'b1; up = 1'b1;
        tick("m16_up1");
        check("m16.q_15", 32'(q16), 15);
        tick("m16_up2");
        check("m16.q_end", 32'(q16), SAT ? 15 : 0);
        check("m16.wrap_end", 32'(wrap16), SAT ? 0 : 1);
        tick("m16_up3");
        check("m16.q_after", 32'(q16), SAT ? 15 : 1);
        check("m16.wrap_after", 32'(wrap16), 0);
        load = 1'b1; din = 4'd1;
        tick("m16_ld1");
        load = 1'b0; up = 1'b0;
        tick("m16_dn1");
        check("m16.q_0", 32'(q16), 0);
        tick("m16_dn2");
        check("m16.q_dn_end", 32'(q16), SAT ? 0 : 15);

        // MODULUS=2: steering direction toward the terminal value wraps every edge.
        load = 1'b1; din = 4'd1;
        tick("m2_ld");
        load = 1'b0; en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            up = (mq[2] == 1);
            tick("m2_b2b");
            check("m2.wrap_b2b", 32'(wrap2), SAT ? 0 : 1);
        end

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            load = ($urandom_range(0, 7) == 0);
            en   = ($urandom_range(0, 3) != 0);
            up   = $urandom_range(0, 1) == 1;
            din  = 4'($urandom_range(0, 15));
            tick("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
